// File: rtl/safebox_pkg.sv
// Shared types and constants for the password entry controller and its timer.
package safebox_pkg;

   localparam int DIGIT_W    = 5;
   localparam int NUM_DIGITS = 4;
   localparam logic [DIGIT_W-1:0] BLANK = 5'h1F;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      FAIL,
      OPEN,
      LOCKOUT
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sb_down_timer.sv
// Loadable down-counter; expired pulses during the last counted cycle unless a reload is pending.
module sb_down_timer #(
   parameter int WIDTH = 29
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   // A reload in the same cycle restarts the interval, so it suppresses expiry.
   assign expired = (count_reg == WIDTH'(1)) && !load;

endmodule

// File: rtl/password_entry_ctrl.sv
// Four-digit keypad password controller with show/mask display, open state and lockout.
module password_entry_ctrl
   import safebox_pkg::*;
#(
   parameter int          SHOW_CYCLES = 50_000_000,
   parameter int          LOCK_CYCLES = 500_000_000,
   parameter int          MAX_FAIL    = 3,
   parameter logic [15:0] INIT_PW     = 16'h1234
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       key_enter,
   input  logic       key_clear,
   input  logic       key_set,
   output logic [4:0] p0,
   output logic [4:0] p1,
   output logic [4:0] p2,
   output logic [4:0] p3,
   output logic       disp_show,
   output logic       unlocked,
   output logic       alarm,
   output logic [1:0] fail_cnt
);

   localparam int TW = $clog2(max2(SHOW_CYCLES, LOCK_CYCLES) + 1);
   localparam logic [1:0] MAX_FAIL_C = 2'(MAX_FAIL);

   state_t             state_reg;
   logic [DIGIT_W-1:0] digit_reg [NUM_DIGITS];
   logic [3:0]         pw_reg    [NUM_DIGITS];
   logic [2:0]         idx_reg;
   logic               disp_show_reg;
   logic               unlocked_reg;
   logic               alarm_reg;
   logic [1:0]         fail_cnt_reg;

   logic            do_clear, do_enter, do_set, do_digit;
   logic            entry_state, full, accept, wipe;
   logic            go_lock, pw_match;
   logic [1:0]      fail_next;
   logic [NUM_DIGITS-1:0] match_bits;
   logic            timer_load, timer_expired;
   logic [TW-1:0]   timer_value;

   // Only the highest-priority pulse acts, even when it is itself ignored.
   assign do_clear = key_clear;
   assign do_enter = key_enter && !key_clear;
   assign do_set   = key_set && !key_clear && !key_enter;
   assign do_digit = key_valid && !key_clear && !key_enter && !key_set && (key_code <= 4'd9);

   assign entry_state = (state_reg == IDLE) || (state_reg == ENTRY) || (state_reg == OPEN);
   assign full        = (idx_reg == 3'd4);
   assign accept      = entry_state && do_digit && !full;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_match
         assign match_bits[gi] = (digit_reg[gi] == {1'b0, pw_reg[gi]});
      end
   endgenerate
   assign pw_match = &match_bits;

   assign fail_next = (fail_cnt_reg >= MAX_FAIL_C) ? MAX_FAIL_C : fail_cnt_reg + 2'd1;
   assign go_lock   = (state_reg == FAIL) && (fail_next == MAX_FAIL_C);

   // Every path that discards the entered digits also clears idx and the show flag.
   assign wipe = (entry_state && do_clear)
              || (state_reg == CHECK)
              || (state_reg == FAIL)
              || ((state_reg == OPEN) && do_enter)
              || ((state_reg == OPEN) && do_set && full);

   assign timer_load  = accept || go_lock;
   assign timer_value = go_lock ? TW'(LOCK_CYCLES) : TW'(SHOW_CYCLES);

   sb_down_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .load_value(timer_value),
      .expired   (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         disp_show_reg <= 1'b0;
         unlocked_reg  <= 1'b0;
         alarm_reg     <= 1'b0;
         fail_cnt_reg  <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_reg[i] <= BLANK;
            pw_reg[i]    <= INIT_PW[15-4*i -: 4];
         end
      end else begin
         if (timer_expired) begin
            disp_show_reg <= 1'b0;
         end
         if (accept) begin
            digit_reg[idx_reg[1:0]] <= {1'b0, key_code};
            idx_reg                 <= idx_reg + 3'd1;
            disp_show_reg           <= 1'b1;
         end
         if (wipe) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               digit_reg[i] <= BLANK;
            end
            idx_reg       <= '0;
            disp_show_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg <= ENTRY;
               end
            end
            ENTRY: begin
               if (do_clear) begin
                  state_reg <= IDLE;
               end else if (do_enter && full) begin
                  state_reg <= CHECK;
               end
            end
            CHECK: begin
               if (pw_match) begin
                  state_reg    <= OPEN;
                  unlocked_reg <= 1'b1;
                  fail_cnt_reg <= '0;
               end else begin
                  state_reg <= FAIL;
               end
            end
            FAIL: begin
               fail_cnt_reg <= fail_next;
               if (go_lock) begin
                  state_reg <= LOCKOUT;
                  alarm_reg <= 1'b1;
               end else begin
                  state_reg <= IDLE;
               end
            end
            OPEN: begin
               if (!do_clear && do_enter) begin
                  state_reg    <= IDLE;
                  unlocked_reg <= 1'b0;
               end else if (do_set && full) begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     pw_reg[i] <= digit_reg[i][3:0];
                  end
               end
            end
            LOCKOUT: begin
               if (timer_expired) begin
                  state_reg    <= IDLE;
                  alarm_reg    <= 1'b0;
                  fail_cnt_reg <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign p0        = digit_reg[0];
   assign p1        = digit_reg[1];
   assign p2        = digit_reg[2];
   assign p3        = digit_reg[3];
   assign disp_show = disp_show_reg;
   assign unlocked  = unlocked_reg;
   assign alarm     = alarm_reg;
   assign fail_cnt  = fail_cnt_reg;

endmodule

// File: tb/tb_password_entry_ctrl.sv
// Directed scoreboard bench: stimulus queues expected output snapshots, a negedge monitor checks them.
module tb_password_entry_ctrl;

   localparam logic [4:0] B = 5'h1F;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_enter;
   logic       key_clear;
   logic       key_set;
   logic [4:0] p0, p1, p2, p3;
   logic       disp_show, unlocked, alarm;
   logic [1:0] fail_cnt;

   always #5 clk = ~clk;

   password_entry_ctrl #(
      .SHOW_CYCLES(4),
      .LOCK_CYCLES(10),
      .MAX_FAIL   (3),
      .INIT_PW    (16'h1234)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_enter(key_enter),
      .key_clear(key_clear),
      .key_set  (key_set),
      .p0       (p0),
      .p1       (p1),
      .p2       (p2),
      .p3       (p3),
      .disp_show(disp_show),
      .unlocked (unlocked),
      .alarm    (alarm),
      .fail_cnt (fail_cnt)
   );

   typedef struct {
      string       name;
      int          due;
      logic [24:0] vec;
   } exp_t;

   exp_t sb_q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: the DUT's output word after each edge is compared with any snapshot due for that cycle.
   always @(negedge clk) begin
      logic [24:0] act;
      exp_t        e;
      act = {p0, p1, p2, p3, disp_show, unlocked, alarm, fail_cnt};
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         e = sb_q.pop_front();
         total++;
         if (e.due != cyc || act !== e.vec) begin
            bad++;
            $display("FAIL %s: got p=%h,%h,%h,%h show=%b unl=%b alarm=%b fc=%0d required p=%h,%h,%h,%h show=%b unl=%b alarm=%b fc=%0d",
                     e.name, act[24:20], act[19:15], act[14:10], act[9:5], act[4], act[3], act[2], act[1:0],
                     e.vec[24:20], e.vec[19:15], e.vec[14:10], e.vec[9:5], e.vec[4], e.vec[3], e.vec[2], e.vec[1:0]);
         end else begin
            $display("check %s ok: p=%h,%h,%h,%h show=%b unl=%b alarm=%b fc=%0d",
                     e.name, act[24:20], act[19:15], act[14:10], act[9:5], act[4], act[3], act[2], act[1:0]);
         end
      end
   end

   task automatic expect_out(input string name, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d, input logic ds,
                             input logic ul, input logic al, input logic [1:0] fc);
      exp_t e;
      e.name = name;
      e.due  = cyc;
      e.vec  = {a, b, c, d, ds, ul, al, fc};
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic digit(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      step();
      key_valid = 1'b0;
   endtask

   task automatic enter();
      key_enter = 1'b1;
      step();
      key_enter = 1'b0;
   endtask

   task automatic clear();
      key_clear = 1'b1;
      step();
      key_clear = 1'b0;
   endtask

   task automatic set_pw();
      key_set = 1'b1;
      step();
      key_set = 1'b0;
   endtask

   task automatic digits4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      digit(a);
      digit(b);
      digit(c);
      digit(d);
   endtask

   // Four digits, enter, then the single CHECK cycle.
   task automatic attempt(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      digits4(a, b, c, d);
      enter();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      key_valid = 1'b1;
      key_code  = 4'd5;
      key_enter = 1'b0;
      key_clear = 1'b0;
      key_set   = 1'b0;
      idle(2);
      expect_out("reset", B, B, B, B, 0, 0, 0, 0);
      rst       = 1'b0;
      key_valid = 1'b0;

      digit(4'd12);
      expect_out("code12_ignored", B, B, B, B, 0, 0, 0, 0);
      digit(4'd1); digit(4'd2); digit(4'd3);
      expect_out("three_digits", 5'h01, 5'h02, 5'h03, B, 1, 0, 0, 0);
      enter();
      expect_out("enter_short", 5'h01, 5'h02, 5'h03, B, 1, 0, 0, 0);
      step();
      expect_out("no_check_short", 5'h01, 5'h02, 5'h03, B, 1, 0, 0, 0);
      digit(4'd4); digit(4'd5);
      expect_out("fifth_ignored", 5'h01, 5'h02, 5'h03, 5'h04, 1, 0, 0, 0);
      enter();
      expect_out("in_check", 5'h01, 5'h02, 5'h03, 5'h04, 1, 0, 0, 0);
      step();
      expect_out("open_1234", B, B, B, B, 0, 1, 0, 0);

      digit(4'd7);
      expect_out("show7", 5'h07, B, B, B, 1, 1, 0, 0);
      idle(3);
      expect_out("show7_held", 5'h07, B, B, B, 1, 1, 0, 0);
      idle(1);
      expect_out("show7_masked", 5'h07, B, B, B, 0, 1, 0, 0);
      clear();
      expect_out("clear_in_open", B, B, B, B, 0, 1, 0, 0);
      enter();
      expect_out("lock_from_open", B, B, B, B, 0, 0, 0, 0);

      attempt(4'd9, 4'd9, 4'd9, 4'd9);
      step();
      expect_out("fail_1", B, B, B, B, 0, 0, 0, 1);
      attempt(4'd9, 4'd9, 4'd9, 4'd9);
      step();
      expect_out("fail_2", B, B, B, B, 0, 0, 0, 2);
      attempt(4'd9, 4'd9, 4'd9, 4'd9);
      step();
      expect_out("lockout_enter", B, B, B, B, 0, 0, 1, 3);
      digit(4'd1);
      expect_out("lockout_key_ignored", B, B, B, B, 0, 0, 1, 3);
      clear();
      enter();
      idle(6);
      expect_out("lockout_cycle10", B, B, B, B, 0, 0, 1, 3);
      idle(1);
      expect_out("lockout_done", B, B, B, B, 0, 0, 0, 0);

      digits4(4'd1, 4'd2, 4'd3, 4'd4);
      expect_out("full_entry", 5'h01, 5'h02, 5'h03, 5'h04, 1, 0, 0, 0);
      key_clear = 1'b1;
      key_enter = 1'b1;
      step();
      key_clear = 1'b0;
      key_enter = 1'b0;
      expect_out("clear_beats_enter", B, B, B, B, 0, 0, 0, 0);
      step();
      expect_out("no_check_after_clear", B, B, B, B, 0, 0, 0, 0);
      attempt(4'd1, 4'd2, 4'd3, 4'd4);
      expect_out("reopen", B, B, B, B, 0, 1, 0, 0);

      digits4(4'd5, 4'd6, 4'd7, 4'd8);
      expect_out("new_digits", 5'h05, 5'h06, 5'h07, 5'h08, 1, 1, 0, 0);
      set_pw();
      expect_out("set_pw", B, B, B, B, 0, 1, 0, 0);
      enter();
      expect_out("leave_open", B, B, B, B, 0, 0, 0, 0);
      attempt(4'd5, 4'd6, 4'd7, 4'd8);
      expect_out("new_pw_open", B, B, B, B, 0, 1, 0, 0);
      enter();
      attempt(4'd1, 4'd2, 4'd3, 4'd4);
      expect_out("old_pw_checked", B, B, B, B, 0, 0, 0, 0);
      step();
      expect_out("old_pw_fail", B, B, B, B, 0, 0, 0, 1);

      attempt(4'd0, 4'd0, 4'd0, 4'd0);
      step();
      expect_out("fail_again", B, B, B, B, 0, 0, 0, 2);
      attempt(4'd0, 4'd0, 4'd0, 4'd0);
      step();
      expect_out("lockout_again", B, B, B, B, 0, 0, 1, 3);
      idle(3);
      expect_out("lockout_again_hold", B, B, B, B, 0, 0, 1, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_out("reset_in_lockout", B, B, B, B, 0, 0, 0, 0);
      attempt(4'd1, 4'd2, 4'd3, 4'd4);
      expect_out("init_pw_restored", B, B, B, B, 0, 1, 0, 0);

      idle(2);
      if (sb_q.size() != 0) begin
         $display("FAIL leftover: got %0d unchecked snapshots, required 0", sb_q.size());
         bad += sb_q.size();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
